// File: rtl/reg_bus_pkg.sv
// Shared register-bus definitions: command codes, response bytes, park address
// and master FSM state encodings, reused by the transmitter side and bank modules.
package reg_bus_pkg;

    localparam logic [7:0] RB_CMD_WR    = 8'h01;
    localparam logic [7:0] RB_CMD_RD    = 8'h02;
    localparam logic [7:0] RB_ACK_BYTE  = 8'hA5;
    localparam logic [7:0] RB_NAK_BYTE  = 8'h5A;
    localparam logic [7:0] RB_PARK_ADDR = 8'hFF;

    typedef logic [2:0] rb_state_t;

    localparam rb_state_t ST_IDLE      = 3'd0;
    localparam rb_state_t ST_GET_ADDR  = 3'd1;
    localparam rb_state_t ST_GET_DATA  = 3'd2;
    localparam rb_state_t ST_WRITE     = 3'd3;
    localparam rb_state_t ST_READ_WAIT = 3'd4;
    localparam rb_state_t ST_SEND      = 3'd5;

    function automatic logic rb_is_cmd(input logic [7:0] b, input logic [7:0] wr_code,
                                       input logic [7:0] rd_code);
        return (b == wr_code) || (b == rd_code);
    endfunction

endpackage

// File: rtl/reg_bus_timeout.sv
// Inter-byte timeout counter: counts enabled cycles, clears on request, and
// strobes o_expired on the cycle the count would reach LIMIT (LIMIT=0 disables).
module reg_bus_timeout
    import reg_bus_pkg::*;
#(
    parameter logic [15:0] LIMIT = 16'd10000
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [15:0] r_cnt;

    // Idle-cycle counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 16'd0;
        end else if (i_clr) begin
            r_cnt <= 16'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = (LIMIT != 16'd0) && i_en && (r_cnt == (LIMIT - 16'd1));

endmodule

// File: rtl/reg_bus_master.sv
// Byte-stream command interpreter driving the 8-bit register bus: one write or
// read per command, answered with ACK, NAK or the read byte over valid/ready.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int          RD_LATENCY     = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd10000,
    parameter logic [7:0]  PARK_ADDR      = RB_PARK_ADDR,
    parameter logic [7:0]  ACK_BYTE       = RB_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE       = RB_NAK_BYTE,
    parameter logic [7:0]  CMD_WR         = RB_CMD_WR,
    parameter logic [7:0]  CMD_RD         = RB_CMD_RD
)(
    input  logic       i_clk_10,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic [7:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_wr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_overrun
);

    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);

    rb_state_t  r_state;
    rb_state_t  w_state_nxt;
    logic [7:0] r_cmd;
    logic [7:0] r_addr_lat;
    logic [3:0] r_wait;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       r_wr;
    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic       r_busy;
    logic       r_overrun;

    logic       w_in_get;
    logic       w_to_en;
    logic       w_to_clr;
    logic       w_expired;
    logic       w_drop_state;

    assign w_in_get     = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
    assign w_to_en      = w_in_get && !i_rx_valid;
    assign w_to_clr     = !w_in_get || i_rx_valid;
    assign w_drop_state = (r_state == ST_WRITE) || (r_state == ST_READ_WAIT) ||
                          (r_state == ST_SEND);

    reg_bus_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk_10),
        .i_rst     (i_rst),
        .i_clr     (w_to_clr),
        .i_en      (w_to_en),
        .o_expired (w_expired)
    );

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (rb_is_cmd(i_rx_data, CMD_WR, CMD_RD)) begin
                        w_state_nxt = ST_GET_ADDR;
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GET_ADDR: begin
                if (i_rx_valid) begin
                    if (r_cmd == CMD_WR) begin
                        w_state_nxt = ST_GET_DATA;
                    end else begin
                        w_state_nxt = ST_READ_WAIT;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GET_ADDR;
                end
            end
            ST_GET_DATA: begin
                if (i_rx_valid) begin
                    w_state_nxt = ST_WRITE;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GET_DATA;
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_SEND;
            end
            ST_READ_WAIT: begin
                if (r_wait == 4'd1) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_READ_WAIT;
                end
            end
            ST_SEND: begin
                if (r_tx_valid && i_tx_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and bus/response datapath
    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= 8'h00;
            r_addr_lat <= 8'h00;
            r_wait     <= 4'd0;
            r_addr     <= PARK_ADDR;
            r_data     <= 8'h00;
            r_wr       <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_overrun <= i_rx_valid && w_drop_state;
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        if (rb_is_cmd(i_rx_data, CMD_WR, CMD_RD)) begin
                            r_cmd <= i_rx_data;
                        end else begin
                            r_tx_data <= NAK_BYTE;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (i_rx_valid) begin
                        r_addr_lat <= i_rx_data;
                        if (r_cmd != CMD_WR) begin
                            r_addr <= i_rx_data;
                            r_wait <= RD_LAT;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (i_rx_valid) begin
                        r_addr <= r_addr_lat;
                        r_data <= i_rx_data;
                        r_wr   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_wr      <= 1'b0;
                    r_addr    <= PARK_ADDR;
                    r_tx_data <= ACK_BYTE;
                end
                ST_READ_WAIT: begin
                    // i_data is taken RD_LATENCY cycles after the address first appears
                    if (r_wait == 4'd1) begin
                        r_tx_data <= i_data;
                        r_addr    <= PARK_ADDR;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                ST_SEND: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                    end else if (i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                    end
                end
                default: begin
                    r_wr <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_wr       = r_wr;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: table of command vectors plus
// hand-written backpressure, overrun, timeout and reset sequences.
module tb_reg_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wr;
    logic [7:0] bank_q;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int wr_cnt, wr_cyc, txv_cnt, txv_first, acc_cnt, ov_cnt, rd_cyc_cnt;
    logic [7:0] wr_addr, wr_data, acc_data;

    always #50 clk = ~clk;

    reg_bus_master #(
        .RD_LATENCY     (2),
        .TIMEOUT_CYCLES (16'd20)
    ) dut (
        .i_clk_10   (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_addr     (addr),
        .o_data     (wdata),
        .o_wr       (wr),
        .i_data     (bank_q),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    // Stub bank with one registered cycle of read latency
    always @(posedge clk) begin
        case (addr)
            8'h11:   bank_q <= 8'h05;
            8'h12:   bank_q <= 8'h3C;
            default: bank_q <= 8'h00;
        endcase
    end

    // Bus and handshake monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = addr;
            wr_data = wdata;
            if (wr_cnt == 1) wr_cyc = cyc;
        end
        if (!wr && addr != 8'hFF) rd_cyc_cnt = rd_cyc_cnt + 1;
        if (tx_valid) begin
            txv_cnt = txv_cnt + 1;
            if (txv_first < 0) txv_first = cyc;
        end
        if (tx_valid && tx_ready) begin
            acc_cnt  = acc_cnt + 1;
            acc_data = tx_data;
        end
        if (overrun) ov_cnt = ov_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_mon();
        wr_cnt = 0; wr_cyc = -1; txv_cnt = 0; txv_first = -1;
        acc_cnt = 0; ov_cnt = 0; rd_cyc_cnt = 0;
        acc_data = 8'h00; wr_addr = 8'h00; wr_data = 8'h00;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
        rx_valid = 1'b1;
        rx_data = b0; step();
        if (n > 1) begin rx_data = b1; step(); end
        if (n > 2) begin rx_data = b2; step(); end
        rx_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        @(negedge clk);
        chk(name, {5'd0, addr, wdata, wr, tx_data, tx_valid, busy, overrun},
            {5'd0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] a;
        logic [7:0] d;
        int         nbytes;
        int         exp_wr;
        logic [7:0] exp_tx;
        int         exp_rd_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        clr_mon();
        tx_ready = 1'b1;
        send_bytes(v.nbytes, v.cmd, v.a, v.d);
        for (int i = 0; i < 30 && acc_cnt == 0; i++) step();
        step(); step();
        @(negedge clk);
        chk($sformatf("v%0d_acc_cnt", idx), acc_cnt, 1);
        chk($sformatf("v%0d_tx_byte", idx), acc_data, v.exp_tx);
        chk($sformatf("v%0d_wr_cnt", idx), wr_cnt, v.exp_wr);
        chk($sformatf("v%0d_rd_addr_cycles", idx), rd_cyc_cnt, v.exp_rd_cyc);
        chk($sformatf("v%0d_idle_after", idx), {busy, tx_valid, addr}, {1'b0, 1'b0, 8'hFF});
        if (v.exp_wr == 1) begin
            chk($sformatf("v%0d_wr_addr", idx), wr_addr, v.a);
            chk($sformatf("v%0d_wr_data", idx), wr_data, v.d);
            chk($sformatf("v%0d_wr_to_valid", idx), txv_first - wr_cyc, 2);
        end
        tx_ready = 1'b0;
    endtask

    int bp_bad;

    initial begin
        vecs[0] = '{8'h01, 8'h11, 8'h05, 3, 1, 8'hA5, 0};
        vecs[1] = '{8'h02, 8'h11, 8'h00, 2, 0, 8'h05, 2};
        vecs[2] = '{8'h02, 8'h12, 8'h00, 2, 0, 8'h3C, 2};
        vecs[3] = '{8'h01, 8'h00, 8'hFF, 3, 1, 8'hA5, 0};
        vecs[4] = '{8'h02, 8'h40, 8'h00, 2, 0, 8'h00, 2};
        vecs[5] = '{8'h7E, 8'h00, 8'h00, 1, 0, 8'h5A, 0};
        vecs[6] = '{8'hFF, 8'h00, 8'h00, 1, 0, 8'h5A, 0};
        vecs[7] = '{8'h03, 8'h00, 8'h00, 1, 0, 8'h5A, 0};

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        clr_mon();
        step(); step();
        chk_reset_outputs("reset_state");
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Backpressure on a read response
        clr_mon();
        tx_ready = 1'b0;
        send_bytes(2, 8'h02, 8'h12, 8'h00);
        for (int i = 0; i < 20 && txv_cnt == 0; i++) step();
        bp_bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === 8'h3C)) bp_bad = bp_bad + 1;
        end
        chk("bp_stable", bp_bad, 0);
        @(posedge clk); #2;
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_next", {busy, tx_valid}, {1'b0, 1'b0});
        for (int i = 0; i < 5; i++) step();
        chk("bp_acc_cnt", acc_cnt, 1);
        chk("bp_acc_data", acc_data, 8'h3C);
        chk("bp_no_wr", wr_cnt, 0);

        // Overrun while a NAK waits in SEND
        clr_mon();
        send_bytes(1, 8'h7E, 8'h00, 8'h00);
        for (int i = 0; i < 20 && txv_cnt == 0; i++) step();
        rx_valid = 1'b1; rx_data = 8'h33;
        step();
        rx_valid = 1'b0;
        step(); step(); step();
        @(negedge clk);
        chk("ovr_pulse_cnt", ov_cnt, 1);
        chk("ovr_resp_held", {tx_valid, tx_data}, {1'b1, 8'h5A});
        tx_ready = 1'b1;
        for (int i = 0; i < 10 && acc_cnt == 0; i++) step();
        step(); step();
        @(negedge clk);
        chk("ovr_acc", {acc_cnt[7:0], acc_data}, {8'd1, 8'h5A});
        chk("ovr_idle", {busy, addr, wr_cnt[7:0]}, {1'b0, 8'hFF, 8'd0});
        tx_ready = 1'b0;

        // Inter-byte timeout after the address of a write
        clr_mon();
        tx_ready = 1'b1;
        send_bytes(2, 8'h01, 8'h12, 8'h00);
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        chk("to_still_busy", busy, 1'b1);
        for (int i = 0; i < 12; i++) step();
        @(negedge clk);
        chk("to_idle", {busy, addr}, {1'b0, 8'hFF});
        chk("to_no_activity", {wr_cnt[7:0], txv_cnt[7:0]}, {8'd0, 8'd0});
        run_vec(vecs[2], 20);

        // Reset while in READ_WAIT
        clr_mon();
        send_bytes(2, 8'h02, 8'h11, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr_mon();
        chk_reset_outputs("rst_rw_outputs");
        for (int i = 0; i < 10; i++) step();
        chk("rst_rw_quiet", {wr_cnt[7:0], txv_cnt[7:0]}, {8'd0, 8'd0});

        // Reset while in WRITE
        send_bytes(3, 8'h01, 8'h20, 8'h77);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr_mon();
        chk_reset_outputs("rst_wr_outputs");
        for (int i = 0; i < 10; i++) step();
        chk("rst_wr_quiet", {wr_cnt[7:0], txv_cnt[7:0]}, {8'd0, 8'd0});

        run_vec(vecs[0], 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

endmodule
